enemy_render_ctrl: RTL and testbench
====================================

Name: enemy_render_ctrl

Overview:
- Per-enemy frame sequencer. Sits between the game-tick source and the enemy movement datapath on one side, and the VGA adapter on the other.
- On each frame start it does three things in order:
  1. Erases the sprite box last drawn for the enemy.
  2. Requests one position update from the enemy datapath and waits for its done handshake.
  3. Draws the sprite box at the new position.
- Produces one pixel write per cycle on the VGA adapter plot interface.

Parameters:
- SPRITE_W, 4, sprite width in pixels (1..8)
- SPRITE_H, 4, sprite height in pixels (1..8)
- BG_COLOUR, 3'b000, colour used for erase writes
- X_MAX, 159, last visible column
- Y_MAX, 119, last visible row

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- start  input  1  frame request, sampled in IDLE only
- space_pressed  input  1  synchronous game restart / abort
- enemy_x  input  8  current enemy column from the enemy datapath
- enemy_y  input  7  current enemy row from the enemy datapath
- enemy_colour  input  3  sprite colour from the enemy datapath
- done_update_enemy  input  1  enemy datapath update-complete flag
- update_enemy  output  1  update request to the enemy datapath
- vga_x  output  8  pixel column
- vga_y  output  7  pixel row
- vga_colour  output  3  pixel colour
- vga_plot  output  1  pixel write enable
- busy  output  1  high in any state other than IDLE
- done_render  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, all outputs 0, pixel counters 0.
  - drawn_x=0, drawn_y=0, have_drawn=0.
- States: IDLE, ERASE, UPDATE, DRAW, DONE.
- IDLE:
  - On start=1, go to ERASE if have_drawn=1, otherwise go to UPDATE.
  - start is ignored in every other state.
- ERASE:
  - Lasts exactly SPRITE_W*SPRITE_H cycles, one pixel per cycle.
  - Raster order: col fastest, then row.
  - Pixel address: px = drawn_x + col, py = drawn_y + row; vga_colour = BG_COLOUR.
  - After the last pixel, go to UPDATE.
- UPDATE:
  - update_enemy=1 and vga_plot=0 while in this state.
  - On the cycle done_update_enemy=1 is sampled, latch drawn_x=enemy_x and drawn_y=enemy_y, set have_drawn=1, then go to DRAW.
  - update_enemy is 0 from the next cycle onward.
  - No timeout; the enemy datapath divider determines the wait.
- DRAW:
  - Same raster walk and length as ERASE, using the latched drawn_x/drawn_y.
  - vga_colour = enemy_colour, sampled live each cycle.
  - After the last pixel, go to DONE.
- DONE: done_render=1 for exactly one cycle, then IDLE.
- Pixel timing:
  - vga_x, vga_y, vga_colour and vga_plot are registered.
  - Pixel k of a walk appears in cycle k+1 after the state is entered.
  - vga_plot is high on exactly SPRITE_W*SPRITE_H cycles per walk, minus clipped pixels.
- Arithmetic and clipping:
  - px is computed 9 bits wide and py 8 bits wide; no wrap.
  - If px > X_MAX or py > Y_MAX, vga_plot=0 for that cycle. The cycle is still consumed, so walk length is fixed.
  - vga_x/vga_y carry the truncated value during clipped cycles; the value is don't-care.
- space_pressed=1 (synchronous, any state):
  - Next state is IDLE; update_enemy, vga_plot and done_render are 0 next cycle; counters clear.
  - drawn_x, drawn_y and have_drawn are retained, so the next frame erases the full box that may be partially drawn.
  - If space_pressed and start arrive in the same cycle, space_pressed wins; start is dropped.
- Simultaneous events:
  - If done_update_enemy is already high on UPDATE entry, the state is left after one cycle.
  - done_update_enemy outside UPDATE is ignored.
- Reset mid-operation: immediate return to the reset values above; stale screen pixels are not cleaned up.

Test Plan:
- First frame: reset, then start with enemy at (150,110), colour 100, done after 5 cycles. Expect no erase, update_enemy high for 6 cycles, 16 plots covering x 150..153 and y 110..113 in raster order, then a done_render pulse.
- Second frame: enemy moves to (149,110). Expect 16 erase plots of colour 000 at 150..153 × 110..113, then 16 draw plots of colour 100 at 149..152 × 110..113.
- Clip: datapath returns x=158. Expect draw plots only at columns 158 and 159, 8 plots total, and a walk length of still 16 cycles.
- Abort: space_pressed in the 5th DRAW cycle. Expect IDLE the next cycle with vga_plot=0. Next start erases the full 16-pixel box at the latched position.
- Busy guard: start pulsed during ERASE and UPDATE. Expect no extra frame and exactly one done_render.
- Async reset asserted mid-ERASE (between clock edges). Expect outputs 0 immediately; after release, the next start skips ERASE.

Source files
------------

// File: rtl/enemy_render_ctrl.sv
// Per-enemy frame sequencer: erase old sprite box, request one enemy position update, draw new box.
// Latency: pixel outputs are registered and change together with the state, one pixel per cycle.
// Backpressure: none on the VGA side; the UPDATE state waits indefinitely for done_update_enemy.
module enemy_render_ctrl #(
    parameter int         SPRITE_W  = 4,
    parameter int         SPRITE_H  = 4,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       space_pressed,
    input  logic [7:0] enemy_x,
    input  logic [6:0] enemy_y,
    input  logic [2:0] enemy_colour,
    input  logic       done_update_enemy,
    output logic       update_enemy,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done_render
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ERASE  = 3'd1;
    localparam logic [2:0] S_UPDATE = 3'd2;
    localparam logic [2:0] S_DRAW   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [2:0] COL_LAST = 3'(SPRITE_W - 1);
    localparam logic [2:0] ROW_LAST = 3'(SPRITE_H - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] col_q, col_d;
    logic [2:0] row_q, row_d;
    logic [7:0] drawn_x_q, drawn_x_d;
    logic [6:0] drawn_y_q, drawn_y_d;
    logic       have_drawn_q, have_drawn_d;

    logic       update_enemy_q, update_enemy_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;
    logic       done_render_q, done_render_d;

    logic       last_pix;
    logic       in_walk;
    logic [8:0] px;
    logic [7:0] py;

    // Next-state, raster counters and box position latch.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        drawn_x_d    = drawn_x_q;
        drawn_y_d    = drawn_y_q;
        have_drawn_d = have_drawn_q;
        last_pix     = (col_q == COL_LAST) && (row_q == ROW_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = have_drawn_q ? S_ERASE : S_UPDATE;
                    col_d   = 3'd0;
                    row_d   = 3'd0;
                end
            end
            S_ERASE, S_DRAW: begin
                if (last_pix) begin
                    state_d = (state_q == S_ERASE) ? S_UPDATE : S_DONE;
                    col_d   = 3'd0;
                    row_d   = 3'd0;
                end else if (col_q == COL_LAST) begin
                    col_d = 3'd0;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            S_UPDATE: begin
                if (done_update_enemy) begin
                    drawn_x_d    = enemy_x;
                    drawn_y_d    = enemy_y;
                    have_drawn_d = 1'b1;
                    state_d      = S_DRAW;
                    col_d        = 3'd0;
                    row_d        = 3'd0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Restart abandons the frame but keeps the box position so the next frame erases it fully.
        if (space_pressed) begin
            state_d      = S_IDLE;
            col_d        = 3'd0;
            row_d        = 3'd0;
            drawn_x_d    = drawn_x_q;
            drawn_y_d    = drawn_y_q;
            have_drawn_d = have_drawn_q;
        end
    end

    // Output values for the coming cycle, derived from the next state so they line up with it.
    always_comb begin
        in_walk        = (state_d == S_ERASE) || (state_d == S_DRAW);
        px             = {1'b0, drawn_x_d} + 9'(col_d);
        py             = {1'b0, drawn_y_d} + 8'(row_d);
        vga_plot_d     = in_walk && (px <= 9'(X_MAX)) && (py <= 8'(Y_MAX));
        vga_x_d        = in_walk ? px[7:0] : 8'd0;
        vga_y_d        = in_walk ? py[6:0] : 7'd0;
        vga_colour_d   = 3'd0;
        if (state_d == S_ERASE) begin
            vga_colour_d = BG_COLOUR;
        end else if (state_d == S_DRAW) begin
            vga_colour_d = enemy_colour;
        end
        update_enemy_d = (state_d == S_UPDATE);
        done_render_d  = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            col_q          <= 3'd0;
            row_q          <= 3'd0;
            drawn_x_q      <= 8'd0;
            drawn_y_q      <= 7'd0;
            have_drawn_q   <= 1'b0;
            update_enemy_q <= 1'b0;
            vga_x_q        <= 8'd0;
            vga_y_q        <= 7'd0;
            vga_colour_q   <= 3'd0;
            vga_plot_q     <= 1'b0;
            done_render_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            drawn_x_q      <= drawn_x_d;
            drawn_y_q      <= drawn_y_d;
            have_drawn_q   <= have_drawn_d;
            update_enemy_q <= update_enemy_d;
            vga_x_q        <= vga_x_d;
            vga_y_q        <= vga_y_d;
            vga_colour_q   <= vga_colour_d;
            vga_plot_q     <= vga_plot_d;
            done_render_q  <= done_render_d;
        end
    end

    assign update_enemy = update_enemy_q;
    assign vga_x        = vga_x_q;
    assign vga_y        = vga_y_q;
    assign vga_colour   = vga_colour_q;
    assign vga_plot     = vga_plot_q;
    assign done_render  = done_render_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_enemy_render_ctrl.sv
// Bench for enemy_render_ctrl: directed frames from the test plan, then randomized traffic.
// A behavioural frame model predicts every output on every cycle; literal checks pin the model.
// Inputs are driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_enemy_render_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    localparam int P_IDLE   = 0;
    localparam int P_ERASE  = 1;
    localparam int P_UPDATE = 2;
    localparam int P_DRAW   = 3;
    localparam int P_DONE   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       space_pressed;
    logic [7:0] enemy_x;
    logic [6:0] enemy_y;
    logic [2:0] enemy_colour;
    logic       done_update_enemy;
    logic       update_enemy;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done_render;

    enemy_render_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .space_pressed     (space_pressed),
        .enemy_x           (enemy_x),
        .enemy_y           (enemy_y),
        .enemy_colour      (enemy_colour),
        .done_update_enemy (done_update_enemy),
        .update_enemy      (update_enemy),
        .vga_x             (vga_x),
        .vga_y             (vga_y),
        .vga_colour        (vga_colour),
        .vga_plot          (vga_plot),
        .busy              (busy),
        .done_render       (done_render)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // frame model: which phase of the frame we are in and how many pixels of the walk are behind us
    int ph;
    int k;
    int m_dx;
    int m_dy;
    bit m_have;

    // per-scenario observations
    int n_plot;
    int n_upd;
    int n_done;
    int px_q[$];
    int py_q[$];
    int pc_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph     = P_IDLE;
        k      = 0;
        m_dx   = 0;
        m_dy   = 0;
        m_have = 0;
    endtask

    task automatic clear_obs();
        n_plot = 0;
        n_upd  = 0;
        n_done = 0;
        px_q.delete();
        py_q.delete();
        pc_q.delete();
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, compare everything.
    task automatic cyc(input bit st, input bit sp, input bit dn, input int ex, input int ey, input int col);
        int e_px;
        int e_py;
        bit e_plot;
        int e_col;
        @(negedge clk);
        start             = st;
        space_pressed     = sp;
        done_update_enemy = dn;
        enemy_x           = ex[7:0];
        enemy_y           = ey[6:0];
        enemy_colour      = col[2:0];

        if (sp) begin
            ph = P_IDLE;
            k  = 0;
        end else begin
            case (ph)
                P_IDLE: if (st) begin
                    ph = m_have ? P_ERASE : P_UPDATE;
                    k  = 0;
                end
                P_ERASE: if (k == N - 1) begin
                    ph = P_UPDATE;
                    k  = 0;
                end else k++;
                P_UPDATE: if (dn) begin
                    m_dx   = ex & 255;
                    m_dy   = ey & 127;
                    m_have = 1;
                    ph     = P_DRAW;
                    k      = 0;
                end
                P_DRAW: if (k == N - 1) begin
                    ph = P_DONE;
                    k  = 0;
                end else k++;
                default: ph = P_IDLE;
            endcase
        end

        e_px   = m_dx + (k % W);
        e_py   = m_dy + (k / W);
        e_plot = ((ph == P_ERASE) || (ph == P_DRAW)) && (e_px <= 159) && (e_py <= 119);
        e_col  = (ph == P_DRAW) ? (col & 7) : 0;

        @(posedge clk);
        #1;
        check("vga_plot", vga_plot, e_plot);
        check("update_enemy", update_enemy, ph == P_UPDATE);
        check("done_render", done_render, ph == P_DONE);
        check("busy", busy, ph != P_IDLE);
        if (e_plot) begin
            check("vga_x", vga_x, e_px & 255);
            check("vga_y", vga_y, e_py & 127);
            check("vga_colour", vga_colour, e_col);
        end

        if (vga_plot) begin
            n_plot++;
            px_q.push_back(int'(vga_x));
            py_q.push_back(int'(vga_y));
            pc_q.push_back(int'(vga_colour));
        end
        if (update_enemy) n_upd++;
        if (done_render) n_done++;
    endtask

    initial begin
        reset             = 1'b0;
        start             = 1'b0;
        space_pressed     = 1'b0;
        done_update_enemy = 1'b0;
        enemy_x           = 8'd0;
        enemy_y           = 7'd0;
        enemy_colour      = 3'd0;
        model_reset();
        clear_obs();

        #12;
        check("rst_plot", vga_plot, 0);
        check("rst_busy", busy, 0);
        check("rst_update", update_enemy, 0);
        check("rst_done", done_render, 0);
        check("rst_x", vga_x, 0);
        check("rst_y", vga_y, 0);
        check("rst_colour", vga_colour, 0);
        @(negedge clk);
        reset = 1'b1;

        // first frame: no erase, 6 update cycles, 16 plots at 150..153 x 110..113
        clear_obs();
        cyc(1, 0, 0, 150, 110, 4);
        check("f1_skip_erase", update_enemy, 1);
        repeat (5) cyc(0, 0, 0, 150, 110, 4);
        cyc(0, 0, 1, 150, 110, 4);
        repeat (16) cyc(0, 0, 0, 150, 110, 4);
        cyc(0, 0, 0, 150, 110, 4);
        check("f1_upd_cycles", n_upd, 6);
        check("f1_plots", n_plot, 16);
        check("f1_done_pulses", n_done, 1);
        if (px_q.size() == 16) begin
            check("f1_first_x", px_q[0], 150);
            check("f1_first_y", py_q[0], 110);
            check("f1_last_x", px_q[15], 153);
            check("f1_last_y", py_q[15], 113);
            check("f1_px5_x", px_q[5], 151);
            check("f1_px5_y", py_q[5], 111);
            check("f1_colour", pc_q[7], 4);
        end

        // second frame: erase old box, draw at (149,110)
        clear_obs();
        cyc(1, 0, 0, 149, 110, 4);
        repeat (16) cyc(0, 0, 0, 149, 110, 4);
        cyc(0, 0, 1, 149, 110, 4);
        repeat (16) cyc(0, 0, 0, 149, 110, 4);
        cyc(0, 0, 0, 149, 110, 4);
        check("f2_plots", n_plot, 32);
        check("f2_done_pulses", n_done, 1);
        if (px_q.size() == 32) begin
            check("f2_erase_x0", px_q[0], 150);
            check("f2_erase_col", pc_q[0], 0);
            check("f2_erase_last_x", px_q[15], 153);
            check("f2_draw_x0", px_q[16], 149);
            check("f2_draw_col", pc_q[16], 4);
            check("f2_draw_last_x", px_q[31], 152);
            check("f2_draw_last_y", py_q[31], 113);
        end

        // clip: x=158 leaves only columns 158 and 159, walk still 16 cycles
        cyc(1, 0, 0, 158, 110, 2);
        repeat (16) cyc(0, 0, 0, 158, 110, 2);
        clear_obs();
        cyc(0, 0, 1, 158, 110, 2);
        repeat (15) cyc(0, 0, 0, 158, 110, 2);
        check("clip_not_done_early", done_render, 0);
        cyc(0, 0, 0, 158, 110, 2);
        check("clip_walk_len", done_render, 1);
        check("clip_plots", n_plot, 8);
        if (px_q.size() == 8) begin
            check("clip_x0", px_q[0], 158);
            check("clip_x1", px_q[1], 159);
            check("clip_x2", px_q[2], 158);
            check("clip_y7", py_q[7], 113);
        end
        cyc(0, 0, 0, 158, 110, 2);

        // abort in the 5th DRAW cycle, then verify the full latched box is erased
        cyc(1, 0, 0, 100, 50, 5);
        repeat (16) cyc(0, 0, 0, 100, 50, 5);
        cyc(0, 0, 1, 100, 50, 5);
        repeat (4) cyc(0, 0, 0, 100, 50, 5);
        cyc(0, 1, 0, 100, 50, 5);
        check("abort_plot", vga_plot, 0);
        check("abort_busy", busy, 0);
        cyc(1, 1, 0, 100, 50, 5);
        check("space_beats_start", busy, 0);
        clear_obs();
        cyc(1, 0, 0, 100, 50, 5);
        repeat (16) cyc(0, 0, 0, 100, 50, 5);
        check("abort_erase_plots", n_plot, 16);
        if (px_q.size() == 16) begin
            check("abort_erase_x0", px_q[0], 100);
            check("abort_erase_y0", py_q[0], 50);
            check("abort_erase_col", pc_q[9], 0);
            check("abort_erase_y15", py_q[15], 53);
        end
        cyc(0, 0, 1, 100, 50, 5);
        repeat (17) cyc(0, 0, 0, 100, 50, 5);

        // busy guard: start pulses during ERASE and UPDATE are ignored
        clear_obs();
        cyc(1, 0, 0, 60, 40, 3);
        repeat (4) cyc(1, 0, 0, 60, 40, 3);
        repeat (12) cyc(0, 0, 0, 60, 40, 3);
        repeat (3) cyc(1, 0, 0, 60, 40, 3);
        cyc(0, 0, 1, 60, 40, 3);
        repeat (16) cyc(0, 0, 0, 60, 40, 3);
        repeat (5) cyc(0, 0, 0, 60, 40, 3);
        check("guard_done_pulses", n_done, 1);
        check("guard_idle", busy, 0);

        // async reset in the middle of an ERASE
        cyc(1, 0, 0, 10, 10, 1);
        repeat (5) cyc(0, 0, 0, 10, 10, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_plot", vga_plot, 0);
        check("arst_busy", busy, 0);
        check("arst_update", update_enemy, 0);
        check("arst_x", vga_x, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_obs();
        cyc(1, 0, 0, 20, 20, 6);
        check("arst_skip_erase", update_enemy, 1);
        check("arst_no_plot", n_plot, 0);
        cyc(0, 0, 1, 20, 20, 6);
        repeat (17) cyc(0, 0, 0, 20, 20, 6);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit st;
            bit sp;
            bit dn;
            int ex;
            int ey;
            st = ($urandom % 4) == 0;
            sp = ($urandom % 80) == 0;
            dn = ($urandom % 5) == 0;
            ex = ($urandom % 2) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
            ey = ($urandom % 2) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
            cyc(st, sp, dn, ex, ey, int'($urandom % 8));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
